// File: rtl/if_inst_buffer_pkg.sv
// if_inst_buffer_pkg: shared widths and constant words for the fetch/decode instruction buffer
package if_inst_buffer_pkg;
  localparam int REG_BUS = 64;
  localparam int INST_BUS = 32;
  localparam logic [REG_BUS-1:0] ZERO_WORD = '0;
  localparam logic [INST_BUS-1:0] NOP_INST = 32'h0000_0013;
endpackage

// File: rtl/if_inst_buffer_ram.sv
// if_inst_buffer_ram: unreset register array, one write port and one asynchronous read port
module if_inst_buffer_ram #(
  parameter int DEPTH = 4,
  parameter int W = 96
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]             rdata_o
);
  logic [W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/if_inst_buffer.sv
// if_inst_buffer: fetch-to-decode circular queue of {pc, inst} with flush.
// Define IF_INST_BUFFER_BYPASS_EN for a same-cycle path from input to output when empty.
module if_inst_buffer
  import if_inst_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ADDR_W = REG_BUS,
  parameter int INST_W = INST_BUS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          in_pc,
  input  logic [INST_W-1:0]          in_inst,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [INST_W-1:0]          out_inst,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic empty, full, wr_en, rd_en, byp;
  logic [ADDR_W+INST_W-1:0] rd_data;
  always_comb begin
    empty = count_q == '0;
    full = count_q == CW'(DEPTH);
    in_ready = !full && !flush;
`ifdef IF_INST_BUFFER_BYPASS_EN
    byp = empty && in_valid && !flush;
`else
    byp = 1'b0;
`endif
    out_valid = !empty || byp;
    {out_pc, out_inst} = !empty ? rd_data : byp ? {in_pc, in_inst} : '0;
    // a bypassed entry taken by decode in the same cycle never lands in storage
    wr_en = in_valid && in_ready && !(byp && out_ready);
    rd_en = !empty && out_ready && !flush;
    wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(wr_en);
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(rd_en);
    count_d = flush ? '0 : count_q + CW'(wr_en) - CW'(rd_en);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  assign count = count_q;
  if_inst_buffer_ram #(.DEPTH(DEPTH), .W(ADDR_W + INST_W)) u_ram (
    .clk(clk),
    .we_i(wr_en),
    .waddr_i(wr_ptr_q),
    .wdata_i({in_pc, in_inst}),
    .raddr_i(rd_ptr_q),
    .rdata_o(rd_data)
  );
endmodule
